// File: rtl/pac_move_pkg.sv
// Shared types and helpers for the sprite movement scheduler.
package pac_move_pkg;

  localparam int GRID_W = 5;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Select the wall checker bit that corresponds to a direction.
  function automatic logic dir_allowed(input dir_t d, input logic up, input logic down,
                                       input logic left, input logic right);
    case (d)
      DIR_UP:   dir_allowed = up;
      DIR_DOWN: dir_allowed = down;
      DIR_LEFT: dir_allowed = left;
      default:  dir_allowed = right;
    endcase
  endfunction

endpackage

// File: rtl/sprite_move_scheduler_move_step.sv
// One-cell step calculator: next coordinate for a direction plus whether the
// wall checker allows that move. Coordinates never wrap because the checker
// refuses moves off the playfield.
module move_step
  import pac_move_pkg::*;
(
  input  logic [GRID_W-1:0] x,
  input  logic [GRID_W-1:0] y,
  input  dir_t              dir,
  input  logic              allow_up,
  input  logic              allow_down,
  input  logic              allow_left,
  input  logic              allow_right,
  output logic [GRID_W-1:0] nx,
  output logic [GRID_W-1:0] ny,
  output logic              ok
);

  // Compute the stepped coordinate and the matching allow bit.
  always_comb begin
    nx = x;
    ny = y;
    ok = dir_allowed(dir, allow_up, allow_down, allow_left, allow_right);
    case (dir)
      DIR_UP:   ny = y - GRID_W'(1);
      DIR_DOWN: ny = y + GRID_W'(1);
      DIR_LEFT: nx = x - GRID_W'(1);
      default:  nx = x + GRID_W'(1);
    endcase
  end

endmodule

// File: rtl/sprite_move_scheduler.sv
// Scans all sprites once per frame_tick, sharing one external wall checker.
// Each sprite gets an ADDR cycle (checker sees its position) and an EVAL
// cycle (checker result applied: buffered turn, continue, or stop).
// Handshake: dir_req_valid[i] is a single-cycle strobe with no ready; it is
// always accepted and the last strobe before a sprite's EVAL wins.
module sprite_move_scheduler
  import pac_move_pkg::*;
#(
  parameter int N_SPRITES = 5
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_tick,
  input  logic [GRID_W*N_SPRITES-1:0] init_x,
  input  logic [GRID_W*N_SPRITES-1:0] init_y,
  input  logic [2*N_SPRITES-1:0]      dir_req,
  input  logic [N_SPRITES-1:0]        dir_req_valid,
  output logic [GRID_W-1:0]           chk_x,
  output logic [GRID_W-1:0]           chk_y,
  input  logic                        chk_left,
  input  logic                        chk_right,
  input  logic                        chk_up,
  input  logic                        chk_down,
  output logic [GRID_W*N_SPRITES-1:0] pos_x,
  output logic [GRID_W*N_SPRITES-1:0] pos_y,
  output logic [2*N_SPRITES-1:0]      cur_dir,
  output logic [N_SPRITES-1:0]        moving,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  output logic [1:0]                  dbg_state
);

  localparam int IDX_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx;
  logic [GRID_W-1:0]  px [N_SPRITES];
  logic [GRID_W-1:0]  py [N_SPRITES];
  dir_t               cur_dir_r [N_SPRITES];
  dir_t               pend_dir [N_SPRITES];
  logic [N_SPRITES-1:0] pend_valid;
  logic [N_SPRITES-1:0] moving_r;

  logic [GRID_W-1:0]  nx;
  logic [GRID_W-1:0]  ny;
  logic               ok;
  logic               use_pend;
  logic               step_ok;
  dir_t               sel_dir;

  assign next_idx = idx + 1'b1;

  // A pending turn wins only when the checker allows it; otherwise keep course.
  assign use_pend = pend_valid[idx] &&
                    dir_allowed(pend_dir[idx], chk_up, chk_down, chk_left, chk_right);
  assign sel_dir  = use_pend ? pend_dir[idx] : cur_dir_r[idx];
  assign step_ok  = ok && (use_pend || moving_r[idx]);

  move_step u_step (
    .x           (px[idx]),
    .y           (py[idx]),
    .dir         (sel_dir),
    .allow_up    (chk_up),
    .allow_down  (chk_down),
    .allow_left  (chk_left),
    .allow_right (chk_right),
    .nx          (nx),
    .ny          (ny),
    .ok          (ok)
  );

  // Scan FSM, sprite state and the pending-request slots.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      chk_x      <= '0;
      chk_y      <= '0;
      overrun    <= 1'b0;
      pend_valid <= '0;
      moving_r   <= '0;
      for (int i = 0; i < N_SPRITES; i++) begin
        px[i]        <= init_x[GRID_W*i +: GRID_W];
        py[i]        <= init_y[GRID_W*i +: GRID_W];
        cur_dir_r[i] <= DIR_UP;
        pend_dir[i]  <= DIR_UP;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            idx   <= '0;
            chk_x <= px[0];
            chk_y <= py[0];
            state <= ST_ADDR;
          end
        end
        ST_ADDR: state <= ST_EVAL;
        ST_EVAL: begin
          if (step_ok) begin
            px[idx] <= nx;
            py[idx] <= ny;
          end
          if (use_pend) begin
            cur_dir_r[idx]  <= pend_dir[idx];
            pend_valid[idx] <= 1'b0;
          end
          moving_r[idx] <= step_ok;
          if (idx == IDX_W'(N_SPRITES - 1)) begin
            state <= ST_DONE;
          end else begin
            idx   <= next_idx;
            chk_x <= px[next_idx];
            chk_y <= py[next_idx];
            state <= ST_ADDR;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (frame_tick && state != ST_IDLE) overrun <= 1'b1;
      // New requests land after the EVAL clear so a same-cycle write survives.
      for (int i = 0; i < N_SPRITES; i++) begin
        if (dir_req_valid[i]) begin
          pend_dir[i]   <= dir_t'(dir_req[2*i +: 2]);
          pend_valid[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_flat
    assign pos_x[GRID_W*g +: GRID_W] = px[g];
    assign pos_y[GRID_W*g +: GRID_W] = py[g];
    assign cur_dir[2*g +: 2]         = cur_dir_r[g];
  end

  assign moving    = moving_r;
  assign busy      = (state == ST_ADDR) || (state == ST_EVAL);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Bench for sprite_move_scheduler: a behavioural wall map drives the checker
// inputs, and a per-tick reference model predicts every sprite's state.
module tb_sprite_move_scheduler;
  import pac_move_pkg::*;

  localparam int N = 5;
  localparam int W = 5;

  logic           Clk;
  logic           Reset;
  logic           frame_tick;
  logic [W*N-1:0] init_x, init_y;
  logic [2*N-1:0] dir_req;
  logic [N-1:0]   dir_req_valid;
  logic [W-1:0]   chk_x, chk_y;
  logic           chk_left, chk_right, chk_up, chk_down;
  logic [W*N-1:0] pos_x, pos_y;
  logic [2*N-1:0] cur_dir;
  logic [N-1:0]   moving;
  logic           busy, done, overrun;
  logic [1:0]     dbg_state;

  // allow bits indexed by direction value: {right, left, down, up}
  logic [3:0] allow_map [0:31][0:31];
  assign {chk_right, chk_left, chk_down, chk_up} = allow_map[chk_x][chk_y];

  sprite_move_scheduler #(.N_SPRITES(N)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .init_x(init_x), .init_y(init_y),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .chk_x(chk_x), .chk_y(chk_y),
    .chk_left(chk_left), .chk_right(chk_right), .chk_up(chk_up), .chk_down(chk_down),
    .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir), .moving(moving),
    .busy(busy), .done(done), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_x [N], m_y [N], m_dir [N], m_pd [N];
  bit m_mov [N], m_pv [N];
  bit m_ovr;
  int ix [N], iy [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic build_map(input bit random_walls);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) begin
        allow_map[x][y] = 4'b0000;
        if (x < 14 && y < 14) begin
          allow_map[x][y][0] = (y > 0);
          allow_map[x][y][1] = (y < 13);
          allow_map[x][y][2] = (x > 0);
          allow_map[x][y][3] = (x < 13);
          if (random_walls)
            for (int b = 0; b < 4; b++)
              if ($urandom_range(0, 9) < 3) allow_map[x][y][b] = 1'b0;
        end
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = ix[i]; m_y[i] = iy[i]; m_dir[i] = 0; m_pd[i] = 0;
      m_mov[i] = 0; m_pv[i] = 0;
    end
    m_ovr = 0;
  endtask

  task automatic model_step(input int i);
    case (m_dir[i])
      0: m_y[i] = m_y[i] - 1;
      1: m_y[i] = m_y[i] + 1;
      2: m_x[i] = m_x[i] - 1;
      default: m_x[i] = m_x[i] + 1;
    endcase
  endtask

  // One full frame of the movement rules, sprite by sprite.
  task automatic model_tick();
    for (int i = 0; i < N; i++) begin
      if (m_pv[i] && allow_map[m_x[i]][m_y[i]][m_pd[i]]) begin
        m_dir[i] = m_pd[i]; m_pv[i] = 0; model_step(i); m_mov[i] = 1;
      end else if (m_mov[i] && allow_map[m_x[i]][m_y[i]][m_dir[i]]) begin
        model_step(i);
      end else begin
        m_mov[i] = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_x%0d", tag, i), 32'(pos_x[W*i +: W]), m_x[i]);
      check($sformatf("%s_y%0d", tag, i), 32'(pos_y[W*i +: W]), m_y[i]);
      check($sformatf("%s_dir%0d", tag, i), 32'(cur_dir[2*i +: 2]), m_dir[i]);
      check($sformatf("%s_mov%0d", tag, i), 32'(moving[i]), 32'(m_mov[i]));
    end
    check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // driver: one-cycle request strobe issued while idle
  task automatic request(input int i, input int d);
    dir_req[2*i +: 2] = 2'(d);
    dir_req_valid = '0;
    dir_req_valid[i] = 1'b1;
    @(posedge Clk); #1;
    dir_req_valid = '0;
    m_pv[i] = 1; m_pd[i] = d;
  endtask

  // driver: one frame, with optional extra tick, mid-scan request or reset at cycle T+k
  task automatic do_tick(input string tag, input int tick_at, input int req_at,
                         input int req_spr, input int req_dir, input int reset_at);
    int pre_x [N], pre_y [N];
    bit aborted;
    for (int i = 0; i < N; i++) begin pre_x[i] = m_x[i]; pre_y[i] = m_y[i]; end
    if (req_at > 0 && req_at < 2 + 2*req_spr) begin m_pv[req_spr] = 1; m_pd[req_spr] = req_dir; end
    model_tick();
    if (req_at > 0 && req_at >= 2 + 2*req_spr) begin m_pv[req_spr] = 1; m_pd[req_spr] = req_dir; end
    if (tick_at > 0) m_ovr = 1;
    frame_tick = 1'b1;
    for (int k = 1; k <= 2*N + 2; k++) begin
      @(posedge Clk); #1;
      aborted = (reset_at > 0) && (k > reset_at);
      check($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'((k <= 2*N) && !aborted));
      check($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'((k == 2*N + 1) && !aborted));
      if (aborted) check($sformatf("%s_state_k%0d", tag, k), 32'(dbg_state), 0);
      for (int i = 0; i < N; i++) begin
        if (!aborted && k == 1 + 2*i) begin
          check($sformatf("%s_chkx%0d", tag, i), 32'(chk_x), pre_x[i]);
          check($sformatf("%s_chky%0d", tag, i), 32'(chk_y), pre_y[i]);
        end
        if (!aborted && k == 3 + 2*i) begin
          check($sformatf("%s_px%0d", tag, i), 32'(pos_x[W*i +: W]), m_x[i]);
          check($sformatf("%s_py%0d", tag, i), 32'(pos_y[W*i +: W]), m_y[i]);
        end
      end
      frame_tick = (k == tick_at);
      dir_req_valid = '0;
      if (k == req_at) begin
        dir_req[2*req_spr +: 2] = 2'(req_dir);
        dir_req_valid[req_spr] = 1'b1;
      end
      Reset = (k == reset_at);
    end
    frame_tick = 1'b0; dir_req_valid = '0; Reset = 1'b0;
    if (reset_at > 0) model_reset();
    compare_all(tag);
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; dir_req = '0; dir_req_valid = '0;
    for (int i = 0; i < N; i++) begin
      ix[i] = (i == 0) ? 6 : 1; iy[i] = (i == 0) ? 6 : 1;
      init_x[W*i +: W] = W'(ix[i]); init_y[W*i +: W] = W'(iy[i]);
    end
    build_map(0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare_all("reset");
    check("reset_chkx", 32'(chk_x), 0);
    check("reset_chky", 32'(chk_y), 0);
    check("reset_state", 32'(dbg_state), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    do_tick("idle", 0, 0, 0, 0, 0);

    request(0, 3);
    do_tick("right1", 0, 0, 0, 0, 0);
    check("right1_pos0", 32'(pos_x[4:0]), 7);
    check("right1_dir0", 32'(cur_dir[1:0]), 3);
    do_tick("right2", 0, 0, 0, 0, 0);
    check("right2_pos0", 32'(pos_x[4:0]), 8);

    request(0, 0);
    allow_map[8][6][0] = 1'b0;
    do_tick("buf1", 0, 0, 0, 0, 0);
    check("buf1_x0", 32'(pos_x[4:0]), 9);
    do_tick("buf2", 0, 0, 0, 0, 0);
    check("buf2_y0", 32'(pos_y[4:0]), 5);
    check("buf2_dir0", 32'(cur_dir[1:0]), 0);

    request(0, 2);
    do_tick("left", 0, 0, 0, 0, 0);
    allow_map[8][5][2] = 1'b0;
    do_tick("blk1", 0, 0, 0, 0, 0);
    check("blk1_mov0", 32'(moving[0]), 0);
    do_tick("blk2", 0, 0, 0, 0, 0);
    check("blk2_x0", 32'(pos_x[4:0]), 8);

    build_map(0);
    do_tick("ovr", 4, 4, 1, 1, 0);
    check("ovr_flag", 32'(overrun), 1);
    do_tick("late_req", 0, 0, 0, 0, 0);
    check("late_req_y1", 32'(pos_y[9:5]), 2);

    do_tick("midrst", 0, 0, 0, 0, 5);
    check("midrst_ovr", 32'(overrun), 0);

    for (int t = 0; t < 40; t++) begin
      int tick_at, req_at;
      if ($urandom_range(0, 3) == 0) build_map(1);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) request(i, int'($urandom_range(0, 3)));
      tick_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2*N + 1)) : 0;
      req_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2*N + 1)) : 0;
      do_tick($sformatf("rnd%0d", t), tick_at, req_at, int'($urandom_range(0, N - 1)),
              int'($urandom_range(0, 3)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
